// File: rtl/ysyx_220066_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220066_dmem_resp
// Purpose  : Data-memory responder. Serves held read/write requests from an
//            on-chip 64-bit word array after a fixed latency. It applies
//            byte-masked writes, flags illegal accesses and provides a
//            backdoor word-load port.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220066_dmem_resp #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRd,
  input  logic                  MemWr,
  input  logic [63:0]           addr,
  input  logic [2:0]            wr_len,
  input  logic [7:0]            wr_mask,
  input  logic [63:0]           data_Wr,
  output logic [63:0]           data_Rd,
  output logic                  data_valid,
  output logic                  data_error,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [63:0]           ld_data,
  output logic                  ld_ready
);

  localparam int          c_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [63:0] c_SPAN     = 64'(c_DEPTH) << 3;
  localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;

  logic                  r_is_wr;
  logic                  r_err;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [7:0]            r_mask;
  logic [63:0]           r_wdata;

  logic [63:0]           r_rdata;
  logic                  r_valid;
  logic                  r_error;

  logic [63:0]           r_mem [c_DEPTH];

  logic                  w_req;
  logic                  w_capture;
  logic [63:0]           w_off;
  logic                  w_misalign;
  logic                  w_range_err;
  logic                  w_req_err;
  logic                  w_enter_resp;
  logic                  w_sel_err;
  logic                  w_sel_wr;
  logic [DEPTH_LOG2-1:0] w_sel_idx;
  logic                  w_commit;
  logic                  w_bd_we;

  assign w_req     = MemRd | MemWr;
  assign w_capture = (r_state == S_IDLE) & w_req;

  // ---------------------------------------------------------------------------
  // Legality decode of the live request, only meaningful in IDLE
  // ---------------------------------------------------------------------------
  assign w_off = addr - BASE_ADDR;

  always_comb begin
    w_misalign = 1'b0;
    case (wr_len)
      3'd1:    w_misalign = addr[0];
      3'd2:    w_misalign = |addr[1:0];
      3'd3:    w_misalign = |addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_range_err = (addr < BASE_ADDR) | (w_off >= c_SPAN);
  assign w_req_err   = (MemRd & MemWr) | wr_len[2] | w_misalign | w_range_err;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // A requester that lets go of both strobes has abandoned the access.
        if (!w_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_is_wr <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_mask  <= 8'd0;
      r_wdata <= 64'd0;
    end else if (w_capture) begin
      r_is_wr <= MemWr;
      r_err   <= w_req_err;
      r_idx   <= w_off[DEPTH_LOG2+2:3];
      r_mask  <= wr_mask;
      r_wdata <= data_Wr;
    end
  end

  // With a single-cycle latency RESP is entered straight from IDLE, before the
  // capture registers hold the request, so the live decode is used instead.
  assign w_sel_err = (r_state == S_IDLE) ? w_req_err            : r_err;
  assign w_sel_wr  = (r_state == S_IDLE) ? MemWr                : r_is_wr;
  assign w_sel_idx = (r_state == S_IDLE) ? w_off[DEPTH_LOG2+2:3] : r_idx;

  assign w_enter_resp = (w_state_nxt == S_RESP);

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= 64'd0;
    end else begin
      r_valid <= w_enter_resp;
      r_error <= w_enter_resp & w_sel_err;
      if (w_enter_resp & ~w_sel_err & ~w_sel_wr) begin
        r_rdata <= r_mem[w_sel_idx];
      end else begin
        r_rdata <= 64'd0;
      end
    end
  end

  assign data_valid = r_valid;
  assign data_error = r_error;
  assign data_Rd    = r_rdata;

  // ---------------------------------------------------------------------------
  // Word array: backdoor loads only in IDLE, core writes on the edge ending RESP
  // ---------------------------------------------------------------------------
  assign ld_ready = (r_state == S_IDLE) & ~MemRd & ~MemWr;
  assign w_bd_we  = ld_en & ld_ready;
  assign w_commit = rst & (r_state == S_RESP) & r_is_wr & ~r_err;

  always_ff @(posedge clk) begin
    if (w_bd_we) begin
      r_mem[ld_idx] <= ld_data;
    end else if (w_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (r_mask[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220066_dmem_resp.sv
`default_nettype none
// Bench for ysyx_220066_dmem_resp: two instances (latency 2 and 4) checked
// against a word-array reference model with directed and random accesses.
module tb_ysyx_220066_dmem_resp;

  localparam logic [63:0] c_BASE  = 64'h8000_0000;
  localparam int          c_DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRd = 1'b0, MemWr = 1'b0;
  logic [63:0] addr = '0;
  logic [2:0]  wr_len = '0;
  logic [7:0]  wr_mask = '0;
  logic [63:0] data_Wr = '0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_idx = '0;
  logic [63:0] ld_data = '0;
  logic        cur = 1'b0;
  bit          hold_ld = 1'b0;

  logic [63:0] drd_a, drd_b;
  logic        dv_a, dv_b, de_a, de_b, ldr_a, ldr_b;

  wire [63:0] drd = cur ? drd_b : drd_a;
  wire        dv  = cur ? dv_b  : dv_a;
  wire        de  = cur ? de_b  : de_a;
  wire        ldr = cur ? ldr_b : ldr_a;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] mdl [2][c_DEPTH];

  always #5 clk = ~clk;

  ysyx_220066_dmem_resp #(.BASE_ADDR(c_BASE), .DEPTH_LOG2(12), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .MemRd(MemRd & ~cur), .MemWr(MemWr & ~cur),
    .addr(addr), .wr_len(wr_len), .wr_mask(wr_mask), .data_Wr(data_Wr),
    .data_Rd(drd_a), .data_valid(dv_a), .data_error(de_a),
    .ld_en(ld_en & ~cur), .ld_idx(ld_idx), .ld_data(ld_data), .ld_ready(ldr_a)
  );

  ysyx_220066_dmem_resp #(.BASE_ADDR(c_BASE), .DEPTH_LOG2(12), .LATENCY(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .MemRd(MemRd & cur), .MemWr(MemWr & cur),
    .addr(addr), .wr_len(wr_len), .wr_mask(wr_mask), .data_Wr(data_Wr),
    .data_Rd(drd_b), .data_valid(dv_b), .data_error(de_b),
    .ld_en(ld_en & cur), .ld_idx(ld_idx), .ld_data(ld_data), .ld_ready(ldr_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Legality straight from the access rules.
  function automatic bit exp_err(input bit rd, input bit wr, input logic [63:0] a,
                                 input logic [2:0] len);
    bit e = 1'b0;
    if (rd && wr) e = 1'b1;
    if (len >= 3'd4) e = 1'b1;
    else if ((a % (64'd1 << len)) != 64'd0) e = 1'b1;
    if (a < c_BASE || a >= c_BASE + 64'd8 * c_DEPTH) e = 1'b1;
    return e;
  endfunction

  task automatic bd_load(input logic s, input int idx, input logic [63:0] d);
    cur = s;
    @(posedge clk); #1;
    ld_en = 1'b1; ld_idx = 12'(idx); ld_data = d;
    #1 chk("bd_ready", ldr, 1);
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl[s][idx] = d;
  endtask

  // One complete access; leaves the bench in the RESP cycle with strobes low.
  task automatic access(input logic s, input bit rd, input bit wr, input logic [63:0] a,
                        input logic [2:0] len, input logic [7:0] mask,
                        input logic [63:0] wd, output logic [63:0] got);
    int n;
    int lat;
    bit e;
    int idx;
    logic [63:0] exp;
    cur = s;
    lat = s ? 4 : 2;
    @(posedge clk); #1;
    chk("idle_valid", dv, 0);
    MemRd = rd; MemWr = wr; addr = a; wr_len = len; wr_mask = mask; data_Wr = wd;
    ld_en = hold_ld;
    #1 chk("ldrdy_req", ldr, 0);
    e   = exp_err(rd, wr, a, len);
    idx = e ? 0 : int'((a - c_BASE) / 8);
    exp = (e || !rd) ? 64'd0 : mdl[s][idx];
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (dv === 1'b1 || n >= 3 * lat + 8) break;
      chk("ldrdy_wait", ldr, 0);
    end
    chk("latency", 64'(n), 64'(lat));
    chk("error", de, e);
    chk("rdata", drd, exp);
    got = drd;
    MemRd = 1'b0; MemWr = 1'b0;
    #1 chk("ldrdy_resp", ldr, 0);
    if (!e && wr) begin
      for (int b = 0; b < 8; b++)
        if (mask[b]) mdl[s][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic [63:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      cur = 1'(s); #1;
      chk("rst_valid", dv, 0);
      chk("rst_error", de, 0);
      chk("rst_rdata", drd, 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_ldready", ldr, 1);

    // Full preload of both arrays through the backdoor
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < c_DEPTH; i++)
        bd_load(1'(s), i, {$urandom, $urandom});

    // Basic read, latency 2
    bd_load(0, 0, 64'h1122334455667788);
    bd_load(0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    access(0, 1, 0, 64'h8000_0004, 3'd2, 8'h00, 64'd0, got);
    chk("dir_read", got, 64'h1122334455667788);

    // Masked write then back-to-back read of the same word
    access(0, 0, 1, 64'h8000_0008, 3'd3, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, got);
    chk("dir_wr_rdata", got, 0);
    access(0, 1, 0, 64'h8000_0008, 3'd3, 8'h00, 64'd0, got);
    chk("dir_rmw", got, 64'hFFFF_FFFF_CCCC_DDDD);

    // Error cases
    access(0, 1, 0, 64'h8000_0002, 3'd2, 8'h00, 64'd0, got);
    access(0, 1, 0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, got);
    access(0, 1, 0, 64'h8000_8000, 3'd3, 8'h00, 64'd0, got);
    access(0, 1, 1, 64'h8000_0010, 3'd3, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, got);
    access(0, 1, 0, 64'h8000_0000, 3'd5, 8'h00, 64'd0, got);
    access(0, 1, 0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, got);
    access(0, 1, 0, 64'h8000_7FF8, 3'd3, 8'h00, 64'd0, got);

    // Latency 4 instance
    bd_load(1, 2, 64'h0123_4567_89AB_CDEF);
    access(1, 1, 0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, got);
    chk("dir_read_l4", got, 64'h0123_4567_89AB_CDEF);

    // Abandoned write during WAIT on the latency-4 instance
    cur = 1'b1;
    @(posedge clk); #1;
    MemWr = 1'b1; addr = 64'h8000_0018; wr_len = 3'd3; wr_mask = 8'hFF;
    data_Wr = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    chk("drop_valid1", dv, 0);
    @(posedge clk); #1;
    chk("drop_valid2", dv, 0);
    MemWr = 1'b0;
    @(posedge clk); #1;
    chk("drop_ldready", ldr, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("drop_novalid", dv, 0);
    end
    access(1, 1, 0, 64'h8000_0018, 3'd3, 8'h00, 64'd0, got);

    // Reset during WAIT
    cur = 1'b0;
    @(posedge clk); #1;
    MemRd = 1'b1; addr = 64'h8000_0008; wr_len = 3'd3;
    @(posedge clk); #1;
    rst = 1'b0; MemRd = 1'b0;
    @(posedge clk); #1;
    chk("rstw_valid", dv, 0);
    chk("rstw_error", de, 0);
    chk("rstw_rdata", drd, 0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstw_stale", dv, 0);
    end
    access(0, 1, 0, 64'h8000_0008, 3'd3, 8'h00, 64'd0, got);
    chk("rstw_read", got, 64'hFFFF_FFFF_CCCC_DDDD);

    // Backdoor held across a pending request, accepted once back in IDLE
    d = 64'hCAFE_F00D_1234_5678;
    ld_idx = 12'd5; ld_data = d;
    hold_ld = 1'b1;
    access(0, 1, 0, 64'h8000_0028, 3'd3, 8'h00, 64'd0, got);
    hold_ld = 1'b0;
    @(posedge clk); #1;
    chk("bd_retry_ready", ldr, 1);
    chk("bd_retry_valid", dv, 0);
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl[0][5] = d;
    access(0, 1, 0, 64'h8000_0028, 3'd3, 8'h00, 64'd0, got);
    chk("bd_retry_read", got, d);

    // Randomized accesses against the model
    for (int s = 0; s < 2; s++) begin
      for (int it = 0; it < 200; it++) begin
        int unsigned kind, idx, off;
        bit rd, wr;
        logic [2:0] len;
        logic [63:0] a;
        kind = $urandom_range(0, 9);
        rd   = (kind < 5) || (kind == 9);
        wr   = (kind >= 5);
        len  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        idx  = ($urandom_range(0, 19) == 0) ? 4095 : $urandom_range(0, 15);
        off  = $urandom_range(0, 7);
        if ($urandom_range(0, 4) != 0 && len < 3'd4) off = off & ~((32'd1 << len) - 1);
        a = c_BASE + 64'(idx) * 8 + 64'(off);
        case ($urandom_range(0, 19))
          0: a = c_BASE - 64'($urandom_range(1, 64));
          1: a = c_BASE + 64'h8000 + 64'(off);
          default: ;
        endcase
        access(1'(s), rd, wr, a, len, 8'($urandom), {$urandom, $urandom}, got);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
